rggen_register_access_arbiter: RTL and testbench

Round-robin arbiter that shares one register-block access port between REQUESTERS independent hosts, for example a CPU bus bridge and a debug/JTAG bridge. It accepts one request at a time with a valid/ready handshake and holds it on the downstream port until the register block acknowledges. It then returns read data and error status to the requester that issued it. It sits between the host-side bus adapters and the register block's decode logic, which drives the per-bit-field valid/write_data/write_mask signals.

---
 rtl/rggen_register_access_arbiter.sv | 93 +++++++++
 tb/tb_rggen_register_access_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rggen_register_access_arbiter.sv
// rggen_register_access_arbiter: round-robin arbiter sharing one register access port
// among several hosts, with one outstanding access at a time.
module rggen_register_access_arbiter #(
  parameter int REQUESTERS    = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
)(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [REQUESTERS-1:0]            i_request_valid,
  output logic [REQUESTERS-1:0]            o_request_ready,
  input  logic [REQUESTERS*ADDRESS_WIDTH-1:0] i_request_address,
  input  logic [REQUESTERS-1:0]            i_request_write,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] i_request_write_data,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] i_request_mask,
  output logic [REQUESTERS-1:0]            o_response_valid,
  output logic [DATA_WIDTH-1:0]            o_response_read_data,
  output logic                             o_response_error,
  output logic                             o_access_valid,
  output logic [ADDRESS_WIDTH-1:0]         o_access_address,
  output logic                             o_access_write,
  output logic [DATA_WIDTH-1:0]            o_access_write_data,
  output logic [DATA_WIDTH-1:0]            o_access_mask,
  input  logic                             i_access_ready,
  input  logic [DATA_WIDTH-1:0]            i_access_read_data,
  input  logic                             i_access_error
);
  localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPONSE} state_e;
  state_e                state;
  state_e                state_next;
  logic [PW-1:0]         ptr;
  logic [PW-1:0]         idx;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         owner;
  logic                  found;
  logic                  handshake;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  error;
  // Walk downwards so the candidate closest to the pointer is the last to win.
  always_comb begin
    idx   = '0;
    grant = '0;
    found = 1'b0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % REQUESTERS);
      if (i_request_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  assign handshake = (state == IDLE) && found;
  always_comb begin
    state_next = (state == IDLE)   ? (found ? ACCESS : IDLE) :
                 (state == ACCESS) ? (i_access_ready ? RESPONSE : ACCESS) : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr                 <= '0;
      owner               <= '0;
      o_access_address    <= '0;
      o_access_write      <= 1'b0;
      o_access_write_data <= '0;
      o_access_mask       <= '0;
      read_data           <= '0;
      error               <= 1'b0;
    end else begin
      if (handshake) begin
        owner               <= grant;
        o_access_address    <= i_request_address[grant*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        o_access_write      <= i_request_write[grant];
        o_access_write_data <= i_request_write_data[grant*DATA_WIDTH +: DATA_WIDTH];
        o_access_mask       <= i_request_mask[grant*DATA_WIDTH +: DATA_WIDTH];
      end
      if ((state == ACCESS) && i_access_ready) begin
        read_data <= o_access_write ? '0 : i_access_read_data;
        error     <= i_access_error;
      end
      if (state == RESPONSE) ptr <= (int'(owner) + 1 >= REQUESTERS) ? '0 : owner + 1'b1;
    end
  end
  // Ready is gated by reset so it is 0 the instant reset asserts.
  assign o_request_ready      = (i_rst_n && handshake) ? REQUESTERS'(1) << grant : '0;
  assign o_access_valid       = state == ACCESS;
  assign o_response_valid     = (state == RESPONSE) ? REQUESTERS'(1) << owner : '0;
  assign o_response_read_data = (state == RESPONSE) ? read_data : '0;
  assign o_response_error     = (state == RESPONSE) && error;
endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// tb_rggen_register_access_arbiter: directed checks of the round-robin register access arbiter
// with a 2-requester instance and a 4-requester instance for back-to-back traffic.
module tb_rggen_register_access_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rv, ready, wr, rsp;
  logic [15:0] addr;
  logic [63:0] wd, mask;
  logic [31:0] rdata, awd, am, ardata;
  logic [7:0]  aa;
  logic        err, av, aw, aready, aerr;
  logic [1:0]  g;

  logic [3:0]   rv4, ready4, wr4, rsp4;
  logic [31:0]  addr4, rdata4, awd4, am4;
  logic [127:0] wd4, mask4;
  logic [7:0]   aa4;
  logic         err4, av4, aw4;

  int compared = 0;
  int mismatched = 0;

  rggen_register_access_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_request_valid(rv), .o_request_ready(ready), .i_request_address(addr),
    .i_request_write(wr), .i_request_write_data(wd), .i_request_mask(mask),
    .o_response_valid(rsp), .o_response_read_data(rdata), .o_response_error(err),
    .o_access_valid(av), .o_access_address(aa), .o_access_write(aw),
    .o_access_write_data(awd), .o_access_mask(am),
    .i_access_ready(aready), .i_access_read_data(ardata), .i_access_error(aerr)
  );

  rggen_register_access_arbiter #(.REQUESTERS(4), .ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_request_valid(rv4), .o_request_ready(ready4), .i_request_address(addr4),
    .i_request_write(wr4), .i_request_write_data(wd4), .i_request_mask(mask4),
    .o_response_valid(rsp4), .o_response_read_data(rdata4), .o_response_error(err4),
    .o_access_valid(av4), .o_access_address(aa4), .o_access_write(aw4),
    .o_access_write_data(awd4), .o_access_mask(am4),
    .i_access_ready(1'b1), .i_access_read_data(32'hFFFF_FFFF), .i_access_error(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rv = 2'b11; addr = '0; wr = '0; wd = '0; mask = '0;
    aready = 1'b0; ardata = '0; aerr = 1'b0;
    rv4 = '0; addr4 = '0; wr4 = '0; wd4 = '0; mask4 = '0;
    #2;
    chk("rst_ready", ready, 2'b00);
    chk("rst_rsp", rsp, 2'b00);
    chk("rst_av", av, 0);
    chk("rst_addr", aa, 8'h00);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_ready4", ready4, 4'b0000);
    rv = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // single write from requester 0
    rv = 2'b01; addr[7:0] = 8'h10; wr = 2'b01; wd[31:0] = 32'hA5A5_0000;
    mask[31:0] = 32'hFFFF_0000; aready = 1'b1; ardata = 32'hDEAD_BEEF;
    #1 chk("w_ready", ready, 2'b01);
    @(posedge clk) #1 rv = 2'b00;
    @(negedge clk);
    chk("w_av", av, 1);
    chk("w_addr", aa, 8'h10);
    chk("w_wr", aw, 1);
    chk("w_wd", awd, 32'hA5A5_0000);
    chk("w_mask", am, 32'hFFFF_0000);
    chk("w_rsp_early", rsp, 2'b00);
    @(negedge clk);
    chk("w_rsp", rsp, 2'b01);
    chk("w_err", err, 0);
    chk("w_rdata", rdata, 0);
    chk("w_av_off", av, 0);
    @(negedge clk);
    chk("w_rsp_end", rsp, 2'b00);
    // read with wait states from requester 1 (pointer is now 1)
    aready = 1'b0; rv = 2'b10; addr[15:8] = 8'h04; wr = 2'b00;
    wd[63:32] = 32'h5555_5555; mask[63:32] = 32'hFFFF_FFFF;
    #1 chk("r_ready", ready, 2'b10);
    @(posedge clk) #1 rv = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("r_av", av, 1);
      chk("r_addr", aa, 8'h04);
      chk("r_wr", aw, 0);
      chk("r_mask", am, 32'hFFFF_FFFF);
      chk("r_rsp_wait", rsp, 2'b00);
    end
    aready = 1'b1; ardata = 32'h1234_5678; aerr = 1'b1;
    @(posedge clk) #1;
    aready = 1'b0; ardata = '0; aerr = 1'b0;
    @(negedge clk);
    chk("r_rsp", rsp, 2'b10);
    chk("r_rdata", rdata, 32'h1234_5678);
    chk("r_err", err, 1);
    chk("r_av_off", av, 0);
    @(negedge clk);
    chk("r_rsp_end", rsp, 2'b00);
    chk("r_rdata_end", rdata, 0);
    chk("r_err_end", err, 0);
    // contention from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    rv = 2'b11; addr[7:0] = 8'h20; addr[15:8] = 8'h21; wr = 2'b00;
    aready = 1'b1; ardata = 32'hCAFE_0000;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 != 0) ? 2'b10 : 2'b01;
      #1 chk("c_ready", ready, g);
      @(negedge clk);
      chk("c_ready_acc", ready, 2'b00);
      chk("c_addr", aa, (k % 2 != 0) ? 8'h21 : 8'h20);
      @(negedge clk);
      chk("c_ready_rsp", ready, 2'b00);
      chk("c_rsp", rsp, g);
      chk("c_rdata", rdata, 32'hCAFE_0000);
      @(negedge clk);
    end
    rv = 2'b00;
    // requester 1 raises valid during requester 0's access and withdraws it
    rv = 2'b01; aready = 1'b0;
    #1 chk("wd_ready0", ready, 2'b01);
    @(posedge clk) #1 rv = 2'b10;
    @(negedge clk);
    chk("wd_ready_acc", ready, 2'b00);
    chk("wd_addr", aa, 8'h20);
    rv = 2'b00; aready = 1'b1;
    @(negedge clk);
    chk("wd_rsp", rsp, 2'b01);
    @(negedge clk);
    chk("wd_idle_av", av, 0);
    chk("wd_idle_ready", ready, 2'b00);
    rv = 2'b11;
    #1 chk("wd_ptr", ready, 2'b10);
    // reset in the middle of requester 1's access
    @(posedge clk) #1 aready = 1'b0;
    @(negedge clk);
    chk("ra_av", av, 1);
    chk("ra_addr", aa, 8'h21);
    rst_n = 1'b0;
    #1;
    chk("ra_av0", av, 0);
    chk("ra_addr0", aa, 8'h00);
    chk("ra_wd0", awd, 0);
    chk("ra_mask0", am, 0);
    chk("ra_ready0", ready, 2'b00);
    chk("ra_rsp0", rsp, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    rv = 2'b00; aready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("ra_no_rsp", rsp, 2'b00);
      chk("ra_no_av", av, 0);
    end
    rv = 2'b11;
    #1 chk("ra_ptr0", ready, 2'b01);
    @(posedge clk) #1 rv = 2'b00;
    @(negedge clk);
    chk("ra_av_next", av, 1);
    chk("ra_addr_next", aa, 8'h20);
    @(negedge clk);
    chk("ra_rsp_next", rsp, 2'b01);
    @(negedge clk);
    // back-to-back writes from requester 3 of the 4-requester instance
    rv4 = 4'b1000; addr4[31:24] = 8'h33; wr4 = 4'b1000;
    wd4[127:96] = 32'h0BAD_F00D; mask4[127:96] = 32'h0000_FFFF;
    for (int k = 0; k < 3; k++) begin
      #1 chk("b_ready", ready4, 4'b1000);
      @(negedge clk);
      chk("b_av", av4, 1);
      chk("b_addr", aa4, 8'h33);
      chk("b_wd", awd4, 32'h0BAD_F00D);
      chk("b_ready_acc", ready4, 4'b0000);
      @(negedge clk);
      chk("b_rsp", rsp4, 4'b1000);
      chk("b_rdata", rdata4, 0);
      @(negedge clk);
    end
    rv4 = 4'b0000;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
